// File: rtl/dp_operand_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : dp_pkg
// Brief  : Shared constants for the dot-product operand sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package dp_pkg;

  localparam int DP_DATA_W = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_FIRE = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dp_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : dp_operand_sequencer_if
// Brief  : Operand-load, sequencing-control and accelerator-side signals.
// Rev    : 1.0 - initial release
// ============================================================================
interface dp_operand_sequencer_if
  import dp_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = DP_DATA_W
);

  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   seq_len;
  logic              seq_start;
  logic              seq_busy;
  logic              seq_done;
  logic              seq_err;
  logic [DATA_W-1:0] DP_A;
  logic [DATA_W-1:0] DP_B;
  logic              inputs_ready;
  logic              DP_START;
  logic              DP_DONE;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, seq_len, seq_start, DP_DONE,
    input  seq_busy, seq_done, seq_err, DP_A, DP_B, inputs_ready, DP_START
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, seq_len, seq_start, DP_DONE,
    output seq_busy, seq_done, seq_err, DP_A, DP_B, inputs_ready, DP_START
  );

endinterface
`default_nettype wire

// File: rtl/dp_operand_sequencer_bank.sv
`default_nettype none
// ============================================================================
// Module : dp_operand_bank
// Brief  : DEPTH x DATA_W operand register file, sync write, comb read.
// Rev    : 1.0 - initial release
// ============================================================================
module dp_operand_bank
  import dp_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = DP_DATA_W
) (
  input  logic              ACLK,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Storage is intentionally not reset; contents survive a sequencer reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge ACLK) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/dp_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module : dp_operand_sequencer
// Brief  : Streams A/B operand pairs into the dot-product accelerator.
//          Optional WAIT timeout enabled by defining DP_SEQ_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module dp_operand_sequencer
  import dp_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = DP_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  dp_operand_sequencer_if.slave bus
);

  if (TIMEOUT < 1 || DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_cfg
    $error("dp_operand_sequencer: illegal DEPTH/ADDR_W/TIMEOUT combination");
  end

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [ADDR_W:0]   len_q,   len_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;
  logic [DATA_W-1:0] dpa_q,   dpa_d;
  logic [DATA_W-1:0] dpb_q,   dpb_d;
  logic              ir_q,    ir_d;
  logic              dps_q,   dps_d;
`ifdef DP_SEQ_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WAIT_W-1:0] wait_q,  wait_d;
`endif

  logic              w_addr_ok;
  logic              w_wr_ok;
  logic              w_len_ok;
  logic              w_last;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  if (DEPTH < (1 << ADDR_W)) begin : g_addr_chk
    assign w_addr_ok = ({1'b0, bus.wr_addr} < (ADDR_W+1)'(DEPTH));
  end else begin : g_addr_full
    assign w_addr_ok = 1'b1;
  end

  assign w_wr_ok  = bus.wr_en && !busy_q && w_addr_ok;
  assign w_len_ok = (bus.seq_len != '0) && (bus.seq_len <= (ADDR_W+1)'(DEPTH));
  assign w_last   = ({1'b0, idx_q} == (len_q - 1'b1));

  dp_operand_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank_a (
    .ACLK    (ACLK),
    .we_i    (w_wr_ok && (bus.wr_sel == SEL_A)),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (idx_q),
    .rdata_o (w_rd_a)
  );

  dp_operand_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank_b (
    .ACLK    (ACLK),
    .we_i    (w_wr_ok && (bus.wr_sel == SEL_B)),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (idx_q),
    .rdata_o (w_rd_b)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    dpa_d   = dpa_q;
    dpb_d   = dpb_q;
    ir_d    = ir_q;
    dps_d   = dps_q;
`ifdef DP_SEQ_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.seq_start) begin
          if (w_len_ok) begin
            len_d   = bus.seq_len;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // inputs_ready drops here so every element gets a fresh rising edge.
      ST_LOAD: begin
        dpa_d   = w_rd_a;
        dpb_d   = w_rd_b;
        ir_d    = 1'b0;
        dps_d   = w_last;
        state_d = ST_FIRE;
`ifdef DP_SEQ_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      ST_FIRE: begin
        ir_d    = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        ir_d = 1'b0;
        if (bus.DP_DONE) begin
          if (w_last) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
`ifdef DP_SEQ_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          dps_d   = 1'b0;
          dpa_d   = '0;
          dpb_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      // DP_START stays high through this cycle so the accelerator latches.
      ST_FIN: begin
        dps_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dpa_q   <= '0;
      dpb_q   <= '0;
      ir_q    <= 1'b0;
      dps_q   <= 1'b0;
`ifdef DP_SEQ_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dpa_q   <= dpa_d;
      dpb_q   <= dpb_d;
      ir_q    <= ir_d;
      dps_q   <= dps_d;
`ifdef DP_SEQ_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  assign bus.seq_busy     = busy_q;
  assign bus.seq_done     = done_q;
  assign bus.seq_err      = err_q;
  assign bus.DP_A         = dpa_q;
  assign bus.DP_B         = dpb_q;
  assign bus.inputs_ready = ir_q;
  assign bus.DP_START     = dps_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_dp_operand_sequencer
// Brief  : Self-checking bench with a stub accelerator and a vector model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_dp_operand_sequencer;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_fail;
  logic [7:0] refA [16];
  logic [7:0] refB [16];

  dp_operand_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  dp_operand_sequencer #(.DEPTH(16), .ADDR_W(4), .DATA_W(8), .TIMEOUT(64)) dut (
    .ACLK    (clk),
    .ARESETN (rstn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  32'(bus.seq_busy),     0);
    check({tag, "_done"},  32'(bus.seq_done),     0);
    check({tag, "_err"},   32'(bus.seq_err),      0);
    check({tag, "_ir"},    32'(bus.inputs_ready), 0);
    check({tag, "_start"}, 32'(bus.DP_START),     0);
    check({tag, "_dpa"},   32'(bus.DP_A),         0);
    check({tag, "_dpb"},   32'(bus.DP_B),         0);
  endtask

  task automatic wr(input bit sel, input int addr, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = 4'(addr);
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
    if (sel) refB[addr] = data;
    else     refA[addr] = data;
  endtask

  task automatic bad_len(input int len);
    bus.seq_len   = 5'(len);
    bus.seq_start = 1'b1;
    tick();
    bus.seq_start = 1'b0;
    check("badlen_err",  32'(bus.seq_err), 1);
    check("badlen_busy", 32'(bus.seq_busy), 0);
    tick();
    check("badlen_err_pulse", 32'(bus.seq_err), 0);
    check("badlen_no_ir", 32'(bus.inputs_ready), 0);
  endtask

  // Element pairs expected in index order; dot product from the model arrays.
  task automatic do_run(input int n, input int dly, input bit intrude);
    int cyc, pulses, dps_cyc, pend_cnt, done_cyc, acc, exp_acc, err_seen, extra;
    bit prev_ir, pend, finished;
    cyc = 0; pulses = 0; dps_cyc = 0; pend_cnt = 0; done_cyc = -1;
    acc = 0; exp_acc = 0; err_seen = 0; extra = 0;
    prev_ir = 1'b0; pend = 1'b0; finished = 1'b0;
    for (int i = 0; i < n; i++) exp_acc += int'(refA[i]) * int'(refB[i]);
    bus.seq_len   = 5'(n);
    bus.seq_start = 1'b1;
    tick();
    bus.seq_start = 1'b0;
    check("run_busy_after_start", 32'(bus.seq_busy), 1);
    while (!finished && cyc < 800) begin
      bus.DP_DONE   = 1'b0;
      bus.wr_en     = 1'b0;
      bus.seq_start = 1'b0;
      if (intrude && cyc == 4) begin
        bus.wr_en     = 1'b1;
        bus.wr_sel    = 1'b0;
        bus.wr_addr   = 4'd0;
        bus.wr_data   = 8'd9;
        bus.seq_start = 1'b1;
        bus.seq_len   = 5'd3;
      end
      if (bus.inputs_ready && !prev_ir) begin
        if (pulses < n) begin
          check("pair_a", 32'(bus.DP_A), 32'(refA[pulses]));
          check("pair_b", 32'(bus.DP_B), 32'(refB[pulses]));
          check("pair_dp_start", 32'(bus.DP_START), 32'(pulses == n - 1));
        end
        acc += int'(bus.DP_A) * int'(bus.DP_B);
        pulses++;
        pend = 1'b1;
        pend_cnt = dly;
      end
      prev_ir = bus.inputs_ready;
      if (pend) begin
        if (pend_cnt == 0) begin
          bus.DP_DONE = 1'b1;
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (bus.DP_START) dps_cyc++;
      if (bus.seq_err) err_seen++;
      if (bus.seq_done) begin
        finished = 1'b1;
        done_cyc = cyc;
      end else begin
        tick();
        cyc++;
      end
    end
    bus.DP_DONE = 1'b0;
    bus.wr_en   = 1'b0;
    check("run_finished", 32'(finished), 1);
    check("run_done_cycle", 32'(done_cyc), 32'(n * (3 + dly) + 1));
    check("run_pulses", 32'(pulses), 32'(n));
    check("run_result", 32'(acc), 32'(exp_acc));
    check("run_dp_start_cycles", 32'(dps_cyc), 32'(dly + 3));
    check("run_err_none", 32'(err_seen), 0);
    check("run_busy_at_done", 32'(bus.seq_busy), 0);
    check("run_start_at_done", 32'(bus.DP_START), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.seq_done || bus.inputs_ready || bus.seq_busy) extra++;
    end
    check("run_quiet_after", 32'(extra), 0);
  endtask

  initial begin
    int err_cyc, ir_cnt, seen;
    bit prev_ir, hit;
    n_cmp = 0; n_fail = 0;
    rstn = 1'b0;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.seq_len = '0; bus.seq_start = 1'b0; bus.DP_DONE = 1'b0;
    for (int i = 0; i < 16; i++) begin refA[i] = 8'd0; refB[i] = 8'd0; end
    repeat (3) tick();
    check_outputs_zero("reset");
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin wr(1'b0, i, 8'd0); wr(1'b1, i, 8'd0); end

    for (int i = 0; i < 4; i++) begin
      wr(1'b0, i, 8'(i + 1));
      wr(1'b1, i, 8'(i + 5));
    end
    do_run(4, 0, 1'b0);

    wr(1'b0, 0, 8'd255);
    wr(1'b1, 0, 8'd255);
    do_run(1, 0, 1'b0);

    bad_len(0);
    bad_len(17);

    for (int i = 0; i < 16; i++) begin
      wr(1'b0, i, 8'($urandom));
      wr(1'b1, i, 8'($urandom));
    end
    repeat (4) do_run(int'($urandom_range(1, 16)), int'($urandom_range(0, 3)), 1'b0);
    do_run(16, 0, 1'b0);

    wr(1'b0, 0, 8'd42);
    do_run(6, 1, 1'b1);
    do_run(1, 0, 1'b0);

    // Stub accelerator never acknowledges.
    bus.seq_len = 5'd2;
    bus.seq_start = 1'b1;
    tick();
    bus.seq_start = 1'b0;
    err_cyc = -1; ir_cnt = 0;
    for (int c = 0; c < 100 && err_cyc < 0; c++) begin
      if (bus.inputs_ready) ir_cnt++;
      if (bus.seq_err) err_cyc = c;
      else tick();
    end
    check("stall_single_pulse", 32'(ir_cnt), 1);
`ifdef DP_SEQ_TIMEOUT_EN
    check("timeout_cycle", 32'(err_cyc), 66);
    check("timeout_busy", 32'(bus.seq_busy), 0);
    check("timeout_done", 32'(bus.seq_done), 0);
    check("timeout_start", 32'(bus.DP_START), 0);
    check("timeout_ir", 32'(bus.inputs_ready), 0);
    tick();
    check_outputs_zero("after_timeout");
`else
    check("no_timeout_err", 32'(err_cyc), 32'(-1));
    check("no_timeout_busy", 32'(bus.seq_busy), 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
`endif

    bus.seq_len = 5'd4;
    bus.seq_start = 1'b1;
    tick();
    bus.seq_start = 1'b0;
    seen = 0; prev_ir = 1'b0; hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      bus.DP_DONE = 1'b0;
      if (bus.inputs_ready && !prev_ir) begin
        seen++;
        if (seen == 1) bus.DP_DONE = 1'b1;
        else hit = 1'b1;
      end
      prev_ir = bus.inputs_ready;
      if (!hit) tick();
    end
    bus.DP_DONE = 1'b0;
    check("midrun_reached_elem2", 32'(hit), 1);
    #2 rstn = 1'b0;
    #1;
    check_outputs_zero("midrun_reset");
    tick();
    rstn = 1'b1;
    tick();
    do_run(5, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
